// File: rtl/xc_malu_long_seq.sv
// rtl/xc_malu_long_seq.sv - sequencer for multi-precision madd/msub/macc/mmul long arithmetic
// Holds operands and acc/carry/count state for the external datapath and multiplier.
module xc_malu_long_seq #(
   parameter int unsigned MUL_TIMEOUT = 63
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_uop,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [31:0] req_rs3,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] dp_rs1,
   output logic [31:0] dp_rs2,
   output logic [31:0] dp_rs3,
   output logic [3:0]  dp_uop,
   output logic        fsm_init,
   output logic        fsm_msub_1,
   output logic        fsm_macc_1,
   output logic        fsm_mmul_1,
   output logic        fsm_mmul_2,
   output logic        fsm_done,
   output logic [63:0] acc,
   output logic        carry,
   output logic [5:0]  count,
   input  logic [63:0] dp_n_acc,
   input  logic        dp_n_carry,
   input  logic [63:0] dp_result,
   output logic        mul_start,
   output logic        mul_flush,
   input  logic        mul_done,
   input  logic [63:0] mul_result
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_MSUB_1, S_MACC_1, S_MUL_WAIT, S_MMUL_1, S_MMUL_2, S_DONE
   } state_t;

   state_t      state;
   state_t      nxt;
   logic        accept;
   logic        uop_ok;
   logic        timeout;
   logic        acc_load;
   logic [5:0]  count_inc;

   assign accept    = req_valid & req_ready;
   assign uop_ok    = (req_uop != 4'd0) && ((req_uop & (req_uop - 4'd1)) == 4'd0);
   assign timeout   = (count == 6'(MUL_TIMEOUT));
   assign count_inc = (count == 6'd63) ? count : count + 6'd1;
   assign acc_load  = (state == S_INIT && !dp_uop[3]) || state == S_MSUB_1 ||
                      state == S_MACC_1 || state == S_MMUL_1 || state == S_MMUL_2;

   // Error responses (illegal uop, multiplier timeout) always return zero data.
   assign rsp_data  = (state == S_DONE && !rsp_err) ? dp_result : 64'd0;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:     if (accept) nxt = uop_ok ? S_INIT : S_DONE;
         S_INIT: begin
            if (dp_uop[3])      nxt = S_MUL_WAIT;
            else if (dp_uop[1]) nxt = S_MSUB_1;
            else if (dp_uop[2]) nxt = S_MACC_1;
            else                nxt = S_DONE;
         end
         S_MSUB_1:   nxt = S_DONE;
         S_MACC_1:   nxt = S_DONE;
         S_MUL_WAIT: begin
            if (mul_done)     nxt = S_MMUL_1;
            else if (timeout) nxt = S_DONE;
         end
         S_MMUL_1:   nxt = S_MMUL_2;
         S_MMUL_2:   nxt = S_DONE;
         S_DONE:     if (rsp_ready) nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
      if (flush) nxt = S_IDLE;
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         dp_rs1     <= 32'd0;
         dp_rs2     <= 32'd0;
         dp_rs3     <= 32'd0;
         dp_uop     <= 4'd0;
         fsm_init   <= 1'b0;
         fsm_msub_1 <= 1'b0;
         fsm_macc_1 <= 1'b0;
         fsm_mmul_1 <= 1'b0;
         fsm_mmul_2 <= 1'b0;
         fsm_done   <= 1'b0;
         acc        <= 64'd0;
         carry      <= 1'b0;
         count      <= 6'd0;
         mul_start  <= 1'b0;
         mul_flush  <= 1'b0;
      end else begin
         state      <= nxt;
         req_ready  <= (nxt == S_IDLE);
         rsp_valid  <= (nxt == S_DONE);
         fsm_init   <= (nxt == S_INIT);
         fsm_msub_1 <= (nxt == S_MSUB_1);
         fsm_macc_1 <= (nxt == S_MACC_1);
         fsm_mmul_1 <= (nxt == S_MMUL_1);
         fsm_mmul_2 <= (nxt == S_MMUL_2);
         fsm_done   <= (nxt == S_DONE);
         mul_start  <= (nxt == S_INIT) && req_uop[3];
         // Abort the multiplier whenever it may still be running and we leave it behind.
         mul_flush  <= (state == S_MUL_WAIT && (flush || (!mul_done && timeout))) ||
                       (state == S_INIT && dp_uop[3] && flush);

         if (flush) begin
            acc     <= 64'd0;
            carry   <= 1'b0;
            count   <= 6'd0;
            dp_uop  <= 4'd0;
            rsp_err <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     dp_uop  <= req_uop;
                     dp_rs1  <= req_rs1;
                     dp_rs2  <= req_rs2;
                     dp_rs3  <= req_rs3;
                     acc     <= 64'd0;
                     carry   <= 1'b0;
                     count   <= 6'd0;
                     rsp_err <= !uop_ok;
                  end
               end
               S_MUL_WAIT: begin
                  count <= count_inc;
                  if (mul_done)     acc     <= mul_result;
                  else if (timeout) rsp_err <= 1'b1;
               end
               S_DONE: begin
                  if (rsp_ready) begin
                     dp_uop  <= 4'd0;
                     rsp_err <= 1'b0;
                  end
               end
               default: begin
                  count <= count_inc;
                  if (acc_load) begin
                     acc   <= dp_n_acc;
                     carry <= dp_n_carry;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xc_malu_long_seq.sv
// tb/tb_xc_malu_long_seq.sv - directed scoreboard bench for xc_malu_long_seq
// Models the long-arithmetic datapath and a delayed multiplier around the sequencer.
module tb_xc_malu_long_seq;

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        req_valid, req_ready;
   logic [3:0]  req_uop;
   logic [31:0] req_rs1, req_rs2, req_rs3;
   logic        flush;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_err;
   logic [31:0] dp_rs1, dp_rs2, dp_rs3;
   logic [3:0]  dp_uop;
   logic        fsm_init, fsm_msub_1, fsm_macc_1, fsm_mmul_1, fsm_mmul_2, fsm_done;
   logic [63:0] acc;
   logic        carry;
   logic [5:0]  count;
   logic [63:0] dp_n_acc;
   logic        dp_n_carry;
   logic [63:0] dp_result;
   logic        mul_start, mul_flush;
   logic        mul_done = 1'b0;
   logic [63:0] mul_result;

   typedef struct {
      logic [63:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   mul_delay = 4;
   int   mul_cnt = 0;

   xc_malu_long_seq dut (
      .g_clk(g_clk), .g_reset(g_reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_uop(req_uop),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
      .flush(flush),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rs3(dp_rs3), .dp_uop(dp_uop),
      .fsm_init(fsm_init), .fsm_msub_1(fsm_msub_1), .fsm_macc_1(fsm_macc_1),
      .fsm_mmul_1(fsm_mmul_1), .fsm_mmul_2(fsm_mmul_2), .fsm_done(fsm_done),
      .acc(acc), .carry(carry), .count(count),
      .dp_n_acc(dp_n_acc), .dp_n_carry(dp_n_carry), .dp_result(dp_result),
      .mul_start(mul_start), .mul_flush(mul_flush), .mul_done(mul_done), .mul_result(mul_result)
   );

   always #5 g_clk = ~g_clk;

   // Reference datapath: each strobe selects one partial step of the long operation.
   always_comb begin
      dp_n_acc = acc;
      if (fsm_init) begin
         if (dp_uop[0])      dp_n_acc = {32'h0, dp_rs1} + {32'h0, dp_rs2} + {32'h0, dp_rs3};
         else if (dp_uop[1]) dp_n_acc = {31'h0, dp_rs2 > dp_rs1, dp_rs1 - dp_rs2};
         else if (dp_uop[2]) dp_n_acc = {32'h0, dp_rs1} + {32'h0, dp_rs2};
      end else if (fsm_msub_1) dp_n_acc = {acc[63:32], acc[31:0] - dp_rs3};
      else if (fsm_macc_1)     dp_n_acc = acc + {dp_rs3, 32'h0};
      else if (fsm_mmul_1)     dp_n_acc = acc + {32'h0, dp_rs3};
      dp_n_carry = dp_n_acc[32];
   end
   assign dp_result  = acc;
   assign mul_result = {32'h0, dp_rs1} * {32'h0, dp_rs2};

   // Multiplier: mul_done pulses mul_delay cycles after mul_start; 0 means it never answers.
   always @(negedge g_clk) begin
      mul_done = 1'b0;
      if (g_reset || mul_flush) mul_cnt = 0;
      else if (mul_start && mul_delay > 0) mul_cnt = mul_delay;
      else if (mul_cnt > 0) begin
         mul_cnt--;
         if (mul_cnt == 0) mul_done = 1'b1;
      end
   end

   task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic send(input logic [3:0] uop, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
      check(64'(req_ready), 64'd1, "req_ready_before_send");
      req_valid = 1'b1;
      req_uop   = uop;
      req_rs1   = a;
      req_rs2   = b;
      req_rs3   = c;
      @(negedge g_clk);
      req_valid = 1'b0;
   endtask

   task automatic push(input logic [63:0] d, input logic e);
      exp_t x;
      x.data = d;
      x.err  = e;
      sb.push_back(x);
   endtask

   // n0 is the cycle number (accept edge = cycle 0) at the moment of the call.
   task automatic wait_rsp(input int exp_lat, input int n0, input string tag);
      int   n = n0;
      exp_t e;
      while (!rsp_valid && n < 200) begin
         @(negedge g_clk);
         n++;
      end
      check(64'(rsp_valid), 64'd1, {tag, "_valid"});
      if (exp_lat > 0) check(64'(n), 64'(exp_lat), {tag, "_latency"});
      check(64'(sb.size()), 64'd1, {tag, "_sb_depth"});
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check(rsp_data, e.data, {tag, "_data"});
         check(64'(rsp_err), 64'(e.err), {tag, "_err"});
      end
      rsp_ready = 1'b1;
      @(negedge g_clk);
      rsp_ready = 1'b0;
      check(64'(rsp_valid), 64'd0, {tag, "_valid_drop"});
      check(64'(req_ready), 64'd1, {tag, "_ready_back"});
   endtask

   initial begin
      int n;
      logic [31:0] a, b, c;
      g_reset = 1'b1;
      req_valid = 1'b0; req_uop = 4'd0; req_rs1 = 32'd0; req_rs2 = 32'd0; req_rs3 = 32'd0;
      flush = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(negedge g_clk);
      check(64'(req_ready), 64'd1, "rst_req_ready");
      check(64'(rsp_valid), 64'd0, "rst_rsp_valid");
      check(acc, 64'd0, "rst_acc");
      check(64'(count), 64'd0, "rst_count");
      check(64'(dp_uop), 64'd0, "rst_dp_uop");
      check(64'({mul_start, mul_flush, fsm_init, fsm_done, rsp_err}), 64'd0, "rst_strobes");
      g_reset = 1'b0;
      @(negedge g_clk);

      push(64'h00000001_00000001, 1'b0);
      send(4'b0001, 32'hFFFFFFFF, 32'h1, 32'h1);
      check(64'(fsm_init), 64'd1, "madd_fsm_init");
      check(64'(dp_uop), 64'h1, "madd_dp_uop");
      wait_rsp(2, 1, "madd");

      push(64'h00000002_00000000, 1'b0);
      send(4'b0100, 32'h1, 32'hFFFFFFFF, 32'h1);
      check(64'(fsm_init), 64'd1, "macc_fsm_init");
      @(negedge g_clk);
      check(64'(fsm_macc_1), 64'd1, "macc_fsm_macc_1");
      check(64'(carry), 64'd1, "macc_carry_after_init");
      wait_rsp(3, 2, "macc");

      push(64'h00000001_FFFFFFFD, 1'b0);
      send(4'b0010, 32'h5, 32'h7, 32'h1);
      wait_rsp(3, 1, "msub");

      mul_delay = 4;
      push(64'h00000002_00000001, 1'b0);
      send(4'b1000, 32'hFFFFFFFF, 32'h2, 32'h3);
      check(64'(mul_start), 64'd1, "mmul_mul_start");
      wait_rsp(8, 1, "mmul");

      push(64'd0, 1'b1);
      send(4'b0011, 32'h1, 32'h2, 32'h3);
      check(64'(rsp_valid), 64'd1, "illegal_done_next");
      check(64'(rsp_err), 64'd1, "illegal_err");
      for (int i = 0; i < 5; i++) begin
         @(negedge g_clk);
         check(64'(rsp_valid), 64'd1, "illegal_hold_valid");
      end
      wait_rsp(0, 6, "illegal");

      mul_delay = 0;
      push(64'd0, 1'b1);
      send(4'b1000, 32'h3, 32'h4, 32'h5);
      n = 1;
      while (!rsp_valid && n < 200) begin
         @(negedge g_clk);
         n++;
      end
      check(64'(n), 64'd65, "timeout_latency");
      check(64'(mul_flush), 64'd1, "timeout_mul_flush");
      check(64'(count), 64'd63, "timeout_count");
      wait_rsp(0, n, "timeout");

      send(4'b0100, 32'h9, 32'h9, 32'h9);
      @(negedge g_clk);
      check(64'(fsm_macc_1), 64'd1, "flush_in_macc_1");
      flush = 1'b1;
      @(negedge g_clk);
      flush = 1'b0;
      check(acc, 64'd0, "flush_acc");
      check(64'(count), 64'd0, "flush_count");
      check(64'(req_ready), 64'd1, "flush_req_ready");
      repeat (3) begin
         @(negedge g_clk);
         check(64'(rsp_valid), 64'd0, "flush_no_rsp");
      end

      send(4'b1000, 32'h3, 32'h4, 32'h5);
      repeat (3) @(negedge g_clk);
      flush = 1'b1;
      @(negedge g_clk);
      flush = 1'b0;
      check(64'(mul_flush), 64'd1, "flush_mul_wait_mul_flush");
      check(64'(req_ready), 64'd1, "flush_mul_wait_idle");
      @(negedge g_clk);

      req_valid = 1'b1; req_uop = 4'b0001; flush = 1'b1;
      @(negedge g_clk);
      req_valid = 1'b0; flush = 1'b0;
      check(64'(fsm_init), 64'd0, "flush_beats_accept_init");
      check(64'(req_ready), 64'd1, "flush_beats_accept_ready");
      @(negedge g_clk);
      check(64'(rsp_valid), 64'd0, "flush_beats_accept_rsp");

      send(4'b0010, 32'h8, 32'h1, 32'h1);
      @(negedge g_clk);
      g_reset = 1'b1;
      #1;
      check(acc, 64'd0, "midreset_acc");
      check(64'(fsm_msub_1), 64'd0, "midreset_strobe");
      check(64'(req_ready), 64'd1, "midreset_ready");
      @(negedge g_clk);
      g_reset = 1'b0;
      @(negedge g_clk);
      check(64'(rsp_valid), 64'd0, "midreset_no_rsp");

      mul_delay = 2;
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom; c = $urandom;
         push({32'h0, a} + {32'h0, b} + {32'h0, c}, 1'b0);
         send(4'b0001, a, b, c);
         wait_rsp(2, 1, "rand_madd");
         push({32'h0, a} * {32'h0, b} + {32'h0, c}, 1'b0);
         send(4'b1000, a, b, c);
         wait_rsp(6, 1, "rand_mmul");
      end

      check(64'(sb.size()), 64'd0, "sb_empty_at_end");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
